// File: rtl/shift_unit_seq.sv
// Iterative shift unit: moves the latched operand one bit per clock (SLL/SRL/SRA/ROR)
// under a start/busy/done handshake; result holds until the next accepted start.
module shift_unit_seq #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   data_in,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  localparam logic [SHAMT_W-1:0] COUNT_ONE = SHAMT_W'(1);

  state_t             state_q,  state_d;
  logic [SHAMT_W-1:0] count_q,  count_d;
  logic [1:0]         op_q,     op_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               busy_q,   busy_d;
  logic               done_q,   done_d;
  logic [WIDTH-1:0]   step;

  // Single-bit move of the working register, selected by the op latched at start.
  always_comb begin
    step = result_q;
    case (op_q)
      OP_SLL:  step = {result_q[WIDTH-2:0], 1'b0};
      OP_SRL:  step = {1'b0, result_q[WIDTH-1:1]};
      OP_SRA:  step = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
      OP_ROR:  step = {result_q[0], result_q[WIDTH-1:1]};
      default: step = result_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    op_d     = op_q;
    result_d = result_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          result_d = data_in;
          count_d  = shamt;
          op_d     = op;
          state_d  = (shamt != '0) ? SHIFT : DONE;
        end
      end

      SHIFT: begin
        result_d = step;
        count_d  = count_q - COUNT_ONE;
        if (count_q == COUNT_ONE) begin
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Status flags are decoded from the next state so they leave a flop cleanly.
    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      op_q     <= OP_SLL;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      op_q     <= op_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_shift_unit_seq.sv
// Self-checking bench for shift_unit_seq: directed latency/result cases plus a randomized
// run compared every cycle against a transaction-level reference model.
module tb_shift_unit_seq;
  localparam int W  = 32;
  localparam int SW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    op = 2'b00;
  logic [SW-1:0] shamt = '0;
  logic [W-1:0]  data_in = '0;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: one accepted transaction at a time, timed in clock edges.
  int           edge_n    = 0;
  int           free_edge = 0;
  int           acc_edge  = 0;
  int           acc_sh    = 0;
  bit           active    = 1'b0;
  logic [W-1:0] acc_res   = '0;

  shift_unit_seq #(.WIDTH(W), .SHAMT_W(SW)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .shamt   (shamt),
    .data_in (data_in),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_shift(input logic [1:0] o, input int s, input logic [W-1:0] d);
    logic [W-1:0] r;
    case (o)
      2'b00:   r = d << s;
      2'b01:   r = d >> s;
      2'b10:   r = W'($signed(d) >>> s);
      default: r = (s == 0) ? d : ((d >> s) | (d << (W - s)));
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model update on each edge (or async reset).
  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      active    = 1'b0;
      acc_res   = '0;
      free_edge = edge_n + 1;
    end else begin
      edge_n++;
      if (edge_n >= free_edge && start) begin
        active    = 1'b1;
        acc_edge  = edge_n;
        acc_sh    = int'(shamt);
        acc_res   = ref_shift(op, int'(shamt), data_in);
        free_edge = edge_n + int'(shamt) + 2;
      end
    end
  end

  // Cycle-by-cycle compare, sampled on the falling edge.
  initial forever begin
    logic exp_busy, exp_done;
    bit   res_known;
    @(negedge clk);
    exp_busy  = active && edge_n >= acc_edge && edge_n < acc_edge + acc_sh;
    exp_done  = active && edge_n == acc_edge + acc_sh;
    res_known = !active || edge_n >= acc_edge + acc_sh;
    chk("cyc_busy", W'(busy), W'(exp_busy));
    chk("cyc_done", W'(done), W'(exp_done));
    if (res_known) chk("cyc_result", result, acc_res);
  end

  task automatic run_op(input string name, input logic [1:0] o, input int s,
                        input logic [W-1:0] d, input logic [W-1:0] exp);
    int k;
    int busy_cnt;
    @(negedge clk);
    start = 1'b1; op = o; shamt = SW'(s); data_in = d;
    @(negedge clk);
    start = 1'b0; op = 2'($urandom); shamt = SW'($urandom); data_in = $urandom;
    k = 1;
    busy_cnt = 0;
    while (!done && k < 40) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      k++;
    end
    chk({name, "_done_seen"}, W'(done), W'(1));
    chk({name, "_latency"}, W'(k), W'(s + 1));
    chk({name, "_busy_cycles"}, W'(busy_cnt), W'(s));
    chk({name, "_result"}, result, exp);
    $display("[TB] %s op=%0d shamt=%0d data=%h -> result=%h latency=%0d", name, o, s, d, result, k);
    @(negedge clk);
    chk({name, "_done_pulse"}, W'(done), W'(0));
    chk({name, "_result_hold"}, result, exp);
  endtask

  initial begin
    int done_times[$];
    int dones;

    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_times[$];
    int dones;

    // Pin the model itself with hand-computed values.
    chk("model_ror31", ref_shift(2'b11, 31, 32'h8000_0001), 32'h0000_0003);
    chk("model_sra4",  ref_shift(2'b10, 4, 32'hF000_0000), 32'hFF00_0000);

    repeat (3) @(negedge clk);
    chk("reset_busy",   W'(busy), W'(0));
    chk("reset_done",   W'(done), W'(0));
    chk("reset_result", result,   32'h0);
    reset = 1'b0;
    @(negedge clk);

    run_op("sll4",   2'b00, 4,  32'h0000_0001, 32'h0000_0010);
    run_op("sra31",  2'b10, 31, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("srl31",  2'b01, 31, 32'h8000_0000, 32'h0000_0001);
    run_op("ror1",   2'b11, 1,  32'h0000_0001, 32'h8000_0000);
    run_op("sra0",   2'b10, 0,  32'hA5A5_1234, 32'hA5A5_1234);
    run_op("ror31",  2'b11, 31, 32'h8000_0001, 32'h0000_0003);
    run_op("sll31",  2'b00, 31, 32'hFFFF_FFFF, 32'h8000_0000);

    // Start held high: only IDLE accepts, so done pulses are shamt+2 = 5 cycles apart.
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      if (done) done_times.push_back(i);
      start = 1'b1; shamt = SW'(3); op = 2'($urandom); data_in = $urandom;
    end
    @(negedge clk);
    start = 1'b0;
    chk("held_start_pulses", W'(done_times.size() >= 4), W'(1));
    for (int i = 1; i < done_times.size(); i++)
      chk("held_start_spacing", W'(done_times[i] - done_times[i-1]), W'(5));
    $display("[TB] held start: %0d done pulses observed", done_times.size());
    repeat (8) @(negedge clk);

    // Asynchronous reset while an SLL by 8 has count=2 left.
    @(negedge clk);
    start = 1'b1; op = 2'b00; shamt = SW'(8); data_in = 32'h0000_0001;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midreset_busy",   W'(busy), W'(0));
    chk("midreset_done",   W'(done), W'(0));
    chk("midreset_result", result,   32'h0);
    @(negedge clk);
    #2 reset = 1'b0;
    dones = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("midreset_no_done", W'(dones), W'(0));
    $display("[TB] mid-op reset: busy=%0d done=%0d result=%h after release", busy, done, result);
    run_op("post_reset_sll8", 2'b00, 8, 32'h0000_0001, 32'h0000_0100);

    // Randomized traffic, checked cycle by cycle against the model.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      start   = ($urandom_range(0, 2) == 0);
      op      = 2'($urandom);
      shamt   = ($urandom_range(0, 3) == 0) ? SW'($urandom_range(0, 31)) : SW'($urandom_range(0, 5));
      data_in = $urandom;
      if ($urandom_range(0, 499) == 0) begin
        #2 reset = 1'b1;
        @(negedge clk);
        #2 reset = 1'b0;
        $display("[TB] random reset at t=%0t", $time);
      end
    end
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
